// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer blocks.
// Gray/binary conversion on a wide vector; callers zero-extend.
package fifo_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);
  localparam int PTR_MAX    = 32;

  typedef logic [PTR_MAX-1:0] ptr_t;

  function automatic ptr_t bin2gray(
    input ptr_t b
  );
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs keep the upper result bits zero.
  function automatic ptr_t gray2bin(
    input ptr_t g
  );
    ptr_t b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX-2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for Gray pointers crossing clock domains.
// Async active-low reset clears both stages.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full/almost-full and overflow logic
// for the dual-clock FIFO.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 2,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int PW       = ADDR_W + 1
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              wr_rq,
  input  logic [PW-1:0]     rptr_gray,
  input  logic              ovf_clr,
  output logic [ADDR_W-1:0] waddr,
  output logic [PW-1:0]     wptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic              wr_ack,
  output logic [PW-1:0]     wcount,
  output logic              overflow
);

  // Inverting the top two Gray bits marks "one lap ahead".
  localparam logic [PW-1:0] FULL_MASK =
    PW'(3) << (ADDR_W - 1);
  localparam logic [PW-1:0] AF_LVL = PW'(AFULL_LVL);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rbin;
  logic [PW-1:0] lvl_next;
  logic          full_d;
  logic          afull_d;
  ptr_t          rbin_w;
  ptr_t          gnext_w;
  logic          unused_hi;

  sync_2ff #(
    .WIDTH (PW)
  ) u_rsync (
    .clk   (w_clk),
    .rst_n (w_rst_n),
    .d     (rptr_gray),
    .q     (rq2)
  );

  assign wr_ack    = wr_rq & ~full;
  assign wbin_next = wbin + {{ADDR_W{1'b0}}, wr_ack};

  assign gnext_w   = bin2gray(ptr_t'(wbin_next));
  assign rbin_w    = gray2bin(ptr_t'(rq2));
  assign gray_next = gnext_w[PW-1:0];
  assign rbin      = rbin_w[PW-1:0];
  assign unused_hi = ^{gnext_w[PTR_MAX-1:PW],
                       rbin_w[PTR_MAX-1:PW]};

  assign lvl_next = wbin_next - rbin;
  assign full_d   = (gray_next == (rq2 ^ FULL_MASK));
  assign afull_d  = (lvl_next >= AF_LVL);

  assign waddr  = wbin[ADDR_W-1:0];
  assign wcount = wbin - rbin;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= gray_next;
      full        <= full_d;
      almost_full <= afull_d;
    end
  end

  // A write attempt while full beats a concurrent clear.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n)
      overflow <= 1'b0;
    else if (wr_rq & full)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full, DEPTH=8.
// Count-based model feeds a scoreboard queue.
module tb_fifo_wptr_full;

  logic       w_clk = 1'b0;
  logic       w_rst_n;
  logic       wr_rq;
  logic [3:0] rptr_gray;
  logic       ovf_clr;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic       wr_ack;
  logic [3:0] wcount;
  logic       overflow;

  fifo_wptr_full #(
    .DEPTH     (8),
    .AFULL_LVL (6)
  ) dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .wr_rq       (wr_rq),
    .rptr_gray   (rptr_gray),
    .ovf_clr     (ovf_clr),
    .waddr       (waddr),
    .wptr_gray   (wptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .wr_ack      (wr_ack),
    .wcount      (wcount),
    .overflow    (overflow)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [2:0] waddr;
    logic [3:0] wg;
    logic       full;
    logic       af;
    logic [3:0] wc;
    logic       ovf;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  int m_wbin, m_rq1, m_rq2;
  bit m_full, m_af, m_ovf;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    for (int i = 3; i >= 0; i--)
      b |= (((b >> (i+1)) ^ (g >> i)) & 1) << i;
    return b;
  endfunction

  task automatic model_reset();
    m_wbin = 0; m_rq1 = 0; m_rq2 = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
    sbq.delete();
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_waddr"}, 32'(waddr), 0);
    chk({tag, "_wgray"}, 32'(wptr_gray), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_wcount"}, 32'(wcount), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  task automatic cycle(input logic wr,
                       input logic [3:0] rp,
                       input logic clr);
    exp_t e;
    int   acc, nb, rb, lv;
    wr_rq = wr; rptr_gray = rp; ovf_clr = clr;
    #1;
    acc = (wr && !m_full) ? 1 : 0;
    chk("wr_ack", 32'(wr_ack), 32'(acc));
    rb = g2b(m_rq2);
    nb = (m_wbin + acc) & 15;
    lv = (nb - rb) & 15;
    if (wr && m_full) m_ovf = 1;
    else if (clr)     m_ovf = 0;
    m_full = (lv == 8);
    m_af   = (lv >= 6);
    m_rq2  = m_rq1;
    m_rq1  = int'(rp);
    m_wbin = nb;
    e.waddr = 3'(nb & 7);
    e.wg    = 4'(b2g(nb));
    e.full  = m_full;
    e.af    = m_af;
    e.wc    = 4'((nb - g2b(m_rq2)) & 15);
    e.ovf   = m_ovf;
    sbq.push_back(e);
    @(posedge w_clk); #1;
    e = sbq.pop_front();
    chk("waddr", 32'(waddr), 32'(e.waddr));
    chk("wgray", 32'(wptr_gray), 32'(e.wg));
    chk("full", 32'(full), 32'(e.full));
    chk("afull", 32'(almost_full), 32'(e.af));
    chk("wcount", 32'(wcount), 32'(e.wc));
    chk("ovf", 32'(overflow), 32'(e.ovf));
  endtask

  // Entered at posedge+1; reset asserts between edges.
  task automatic async_reset(input string tag);
    wr_rq = 0; ovf_clr = 0; rptr_gray = 0;
    #3 w_rst_n = 0;
    #1 chk_rst(tag);
    model_reset();
    @(posedge w_clk); #1;
    chk_rst({tag, "_hold"});
    w_rst_n = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] gseq [4];
    logic [3:0] rp;
    gseq = '{4'h1, 4'h3, 4'h2, 4'h6};
    w_rst_n = 0; wr_rq = 0;
    rptr_gray = 0; ovf_clr = 0;
    model_reset();
    repeat (2) @(posedge w_clk);
    #1 chk_rst("rst");
    w_rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      chk("fill_waddr", 32'(waddr), 32'(i));
      cycle(1, 0, 0);
      if (i == 4) chk("af_lo", 32'(almost_full), 0);
      if (i == 5) chk("af_hi", 32'(almost_full), 1);
      if (i == 6) chk("full_lo", 32'(full), 0);
    end
    chk("fill_end_waddr", 32'(waddr), 0);
    chk("fill_end_wgray", 32'(wptr_gray), 32'hC);
    chk("fill_end_full", 32'(full), 1);
    chk("fill_end_wcount", 32'(wcount), 8);

    cycle(1, 0, 0);
    cycle(1, 0, 1);
    chk("ovf_set_wins", 32'(overflow), 1);
    chk("ovf_wgray", 32'(wptr_gray), 32'hC);
    cycle(0, 0, 1);
    chk("ovf_clr", 32'(overflow), 0);

    cycle(0, 4'b0001, 0);
    chk("rel_e1", 32'(full), 1);
    cycle(0, 4'b0001, 0);
    chk("rel_e2", 32'(full), 1);
    cycle(0, 4'b0001, 0);
    chk("rel_e3_full", 32'(full), 0);
    chk("rel_e3_wcount", 32'(wcount), 7);
    chk("rel_e3_afull", 32'(almost_full), 1);
    chk("refill_waddr", 32'(waddr), 0);
    cycle(1, 4'b0001, 0);
    chk("refill_full", 32'(full), 1);

    async_reset("rst2");
    for (int i = 0; i < 20; i++) begin
      rp = (i >= 2) ? 4'(b2g((i - 2) & 15)) : 4'h0;
      cycle(1, rp, 0);
      chk("wrap_nofull", 32'(full), 0);
      if (i < 4)
        chk("wrap_gseq", 32'(wptr_gray),
            32'(gseq[i]));
      if (i == 15)
        chk("wrap_g0", 32'(wptr_gray), 0);
    end

    cycle(1, 0, 0);
    cycle(1, 0, 0);
    async_reset("rst3");
    chk("resume_pre", 32'(waddr), 0);
    cycle(1, 0, 0);
    chk("resume_post", 32'(waddr), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-domain pointer and flag generator for the dual-clock FIFO; sits directly upstream of the FIFO storage array and drives its waddr and full inputs. It counts accepted writes and exports a Gray-coded write pointer to the read domain. It also synchronises the read domain's Gray pointer into w_clk and derives full, almost_full, fill level and a sticky overflow flag.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
ADDR_W, $clog2(DEPTH), storage address width; derived, not overridden
AFULL_LVL, DEPTH-2, fill level at or above which almost_full asserts; range 1..DEPTH

Ports:
w_clk  input  1  write-domain clock; sole clock of the block
w_rst_n  input  1  asynchronous active-low reset, write domain
wr_rq  input  1  write request from producer (same signal feeds storage wr_rq)
rptr_gray  input  ADDR_W+1  Gray read pointer from read domain; asynchronous to w_clk
ovf_clr  input  1  synchronous clear of overflow
waddr  output  ADDR_W  storage write address = wbin[ADDR_W-1:0]
wptr_gray  output  ADDR_W+1  registered Gray write pointer to read-domain synchroniser
full  output  1  registered full flag
almost_full  output  1  registered, level >= AFULL_LVL
wr_ack  output  1  combinational, wr_rq & ~full (write accepted this edge)
wcount  output  ADDR_W+1  fill level as seen by write domain, 0..DEPTH
overflow  output  1  sticky: write attempted while full

Behaviour:
- One clock: w_clk. Reset asynchronous active-low: w_rst_n; polarity and synchronicity fixed.
- Reset (w_rst_n low, immediate): wbin=0, wptr_gray=0, both synchroniser stages=0, full=0, almost_full=0, overflow=0. Hence waddr=0, wcount=0.
- Internal binary pointer wbin, ADDR_W+1 bits; MSB is wrap bit.
- Accepted write: rising w_clk with wr_rq=1 and full=0.
  - wbin <= wbin+1, modulo 2^(ADDR_W+1).
  - wptr_gray <= (wbin+1) ^ ((wbin+1)>>1).
- Write while full: pointer unchanged, overflow <= 1.
- Read pointer sync: rptr_gray passes through 2 flops (rq1, rq2). No logic between them.
- full <= (gray_next == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]}).
  - gray_next is the Gray of the post-edge pointer (incremented or not).
  - For ADDR_W=1, the compare is the full 2-bit inversion.
- wcount (combinational) = wbin - gray2bin(rq2), modulo 2^(ADDR_W+1).
- almost_full <= (wbin_next - gray2bin(rq2)) >= AFULL_LVL, registered.
- Latency:
  - full and almost_full assert on the same edge that accepts the triggering write; no write is ever accepted into a full FIFO.
  - Release is pessimistic. A rptr_gray change propagates to full/almost_full on the 3rd w_clk edge: rq1, then rq2, then flag register.
- Wrap: wbin DEPTH-1 -> DEPTH sets waddr to 0 and toggles the MSB. wbin 2*DEPTH-1 -> 0.
- Simultaneous wr_rq and rptr_gray change: the write is judged against the current full; the read is seen later via the synchroniser.
- ovf_clr with a concurrent write-while-full: set wins, overflow stays 1.
- Reset asserted mid-operation: all state clears immediately. The read domain is responsible for its own reset; rptr_gray is not assumed to be 0.

Decomposition:
- Shared package fifo_pkg:
  - functions bin2gray and gray2bin, parameterised by width
  - localparam convention ADDR_W = $clog2(DEPTH)
- One sub-module: sync_2ff (WIDTH parameter; clk, rst_n, d, q; two-flop async-reset synchroniser). The read-side pointer block reuses it.

Test Plan:
- Reset hold with rptr_gray=0 -> waddr=0, wptr_gray=0, full=0, almost_full=0, wcount=0, overflow=0.
- DEPTH=8, rptr_gray=0, wr_rq high for 8 edges:
  - waddr 0..7 then 0; wptr_gray ends 4'b1100
  - almost_full high after the 6th write; full high after the 8th; wcount=8
- Continue wr_rq for 2 more edges -> wr_ack=0, wptr_gray stays 4'b1100, overflow=1. Pulse ovf_clr -> overflow=0 next edge.
- From full, set rptr_gray=4'b0001 -> full=0 on the 3rd w_clk edge after, wcount=7, almost_full=1. Next write -> waddr=0 accepted, full=1 again.
- Wrap: 20 writes with rptr_gray tracking 2 behind:
  - wptr_gray sequence 0001,0011,0010,0110,... wraps to 0000 after 16
  - full never asserts
- Assert w_rst_n low mid-burst asynchronously, between clock edges -> all outputs return to reset values without a clock edge. Writes resume at waddr=0 after release.
